// File: rtl/alu_pkg.sv
// alu_pkg: ALU op and condition encodings plus the writeback state enum
package alu_pkg;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_ILL  = 2'b11;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_C      = 2'b01;
  localparam logic [1:0] COND_Z      = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;
  typedef enum logic [2:0] {WB_IDLE, WB_EVAL, WB_WRITE, WB_SKIP, WB_DONE} wb_state_t;
  function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
    return cond == COND_ALWAYS || (cond == COND_C && c) || (cond == COND_Z && z);
  endfunction
endpackage

// File: rtl/wb_flag_reg.sv
// wb_flag_reg: architectural C/Z flags; ADD writes both, NAND/SUB write only Z
module wb_flag_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic [1:0] op,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       carry_flag,
  output logic       zero_flag
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (upd) begin
      zero_flag  <= alu_zero;
      carry_flag <= op == ALU_ADD ? alu_carry : carry_flag;
    end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: latches one ALU result, applies conditional execute, writes the RF via valid/ready.
// Define WB_TIMEOUT_EN to abandon a WRITE after TIMEOUT_CYCLES cycles without rf_ready.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int REG_AW         = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic [1:0]        alu_ctrl,
  input  logic [1:0]        cond,
  input  logic [REG_AW-1:0] dest,
  input  logic              rf_ready,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              busy,
  output logic              done,
  output logic              err
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  wb_state_t   state, nxt;
  logic        zero_q, carry_q, err_q, err_nxt, upd, timeout;
  logic [1:0]  op_q, cond_q;
`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = state == WB_WRITE && !rf_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == WB_EVAL) cnt <= '0;
    else if (state == WB_WRITE && !rf_ready) cnt <= cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    upd = 1'b0;
    unique case (state)
      WB_IDLE:  nxt = start ? WB_EVAL : WB_IDLE;
      WB_EVAL: begin
        nxt = op_q != ALU_ILL && cond_pass(cond_q, carry_flag, zero_flag) ? WB_WRITE : WB_SKIP;
        upd = op_q != ALU_ILL && cond_q == COND_NEVER;
      end
      WB_WRITE: begin
        nxt = rf_ready || timeout ? WB_DONE : WB_WRITE;
        upd = rf_ready;
      end
      WB_SKIP:  nxt = WB_DONE;
      WB_DONE:  nxt = WB_IDLE;
      default:  nxt = WB_IDLE;
    endcase
  end
  // error cause is remembered until DONE so err coincides with done
  assign err_nxt = state == WB_IDLE ? 1'b0 : err_q | (state == WB_EVAL && op_q == ALU_ILL) | timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= WB_IDLE;
      err_q      <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      op_q       <= '0;
      cond_q     <= '0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      state <= nxt;
      err_q <= err_nxt;
      if (state == WB_IDLE && start) begin
        zero_q     <= alu_zero;
        carry_q    <= alu_carry;
        op_q       <= alu_ctrl;
        cond_q     <= cond;
        rf_wr_addr <= dest;
        rf_wr_data <= alu_out;
      end
    end
  wb_flag_reg u_flags (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd),
    .op         (op_q),
    .alu_zero   (zero_q),
    .alu_carry  (carry_q),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );
  assign rf_wr_en = state == WB_WRITE;
  assign busy     = state != WB_IDLE;
  assign done     = state == WB_DONE;
  assign err      = done && err_q;
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: table-driven directed checks of alu_writeback (default build)
module tb_alu_writeback;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, alu_zero = 1'b0, alu_carry = 1'b0, rf_ready = 1'b0;
  logic [15:0] alu_out = '0;
  logic [1:0]  alu_ctrl = '0, cond = '0;
  logic [2:0]  dest = '0;
  logic        rf_wr_en, carry_flag, zero_flag, busy, done, err;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  int          passed = 0, total = 0;
  logic        pc = 1'b0, pz = 1'b0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_ctrl(alu_ctrl), .cond(cond), .dest(dest), .rf_ready(rf_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [1:0]  ctrl;
    logic [1:0]  cnd;
    logic [15:0] out;
    logic        z;
    logic        c;
    logic [2:0]  dst;
    int          delay;
    logic        w;
    logic        ec;
    logic        ez;
    logic        ee;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run(input vec_t v, input int idx);
    @(negedge clk);
    alu_ctrl = v.ctrl; cond = v.cnd; alu_out = v.out; alu_zero = v.z; alu_carry = v.c;
    dest = v.dst; start = 1'b1; rf_ready = v.delay == 0;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy_eval", idx), busy, 1);
    chk($sformatf("v%0d_wr_en_eval", idx), rf_wr_en, 0);
    chk($sformatf("v%0d_flags_hold", idx), {carry_flag, zero_flag}, {pc, pz});
    @(negedge clk);
    chk($sformatf("v%0d_wr_en", idx), rf_wr_en, v.w);
    chk($sformatf("v%0d_done_early", idx), done, 0);
    if (v.w) begin
      chk($sformatf("v%0d_addr", idx), rf_wr_addr, v.dst);
      chk($sformatf("v%0d_data", idx), rf_wr_data, v.out);
    end
    for (int i = 0; i < v.delay; i++) begin
      start = 1'b1; alu_out = ~v.out; dest = ~v.dst;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_wait%0d_wr_en", idx, i), rf_wr_en, 1);
      chk($sformatf("v%0d_wait%0d_addr", idx, i), rf_wr_addr, v.dst);
      chk($sformatf("v%0d_wait%0d_data", idx, i), rf_wr_data, v.out);
      chk($sformatf("v%0d_wait%0d_flags", idx, i), {carry_flag, zero_flag}, {pc, pz});
    end
    rf_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_err", idx), err, v.ee);
    chk($sformatf("v%0d_wr_en_done", idx), rf_wr_en, 0);
    chk($sformatf("v%0d_carry", idx), carry_flag, v.ec);
    chk($sformatf("v%0d_zero", idx), zero_flag, v.ez);
    start = 1'b1; rf_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_idle_busy", idx), busy, 0);
    chk($sformatf("v%0d_idle_done", idx), done, 0);
    chk($sformatf("v%0d_idle_err", idx), err, 0);
    pc = v.ec; pz = v.ez;
  endtask

  initial begin
    //            ctrl   cnd    out      z     c     dst   dly  w     C     Z     err
    vecs[0]  = '{2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 3'd3, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 16'h0001, 1'b0, 1'b0, 3'd1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 2'b11, 16'h5555, 1'b0, 1'b0, 3'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 2'b01, 16'h1234, 1'b0, 1'b1, 3'd5, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 2'b11, 16'h0000, 1'b0, 1'b1, 3'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 2'b01, 16'h1234, 1'b1, 1'b0, 3'd5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 2'b11, 16'h0000, 1'b1, 1'b1, 3'd0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 2'b00, 16'hFFFF, 1'b0, 1'b1, 3'd2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 2'b00, 16'h0000, 1'b1, 1'b0, 3'd4, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 2'b10, 16'h00AA, 1'b0, 1'b0, 3'd2, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 2'b10, 16'h0000, 1'b1, 1'b1, 3'd6, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 2'b00, 16'h0000, 1'b1, 1'b1, 3'd1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{2'b00, 2'b00, 16'hBEEF, 1'b0, 1'b1, 3'd7, 5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{2'b11, 2'b11, 16'h0000, 1'b1, 1'b0, 3'd1, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{2'b01, 2'b01, 16'h0F0F, 1'b0, 1'b0, 3'd6, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_outputs", {rf_wr_en, busy, done, err, carry_flag, zero_flag}, 6'b0);
    chk("rst_latches", {rf_wr_addr, rf_wr_data}, 19'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 15; i++) run(vecs[i], i);
    // asynchronous reset while waiting in WRITE
    @(negedge clk);
    alu_ctrl = 2'b00; cond = 2'b00; alu_out = 16'hCAFE; alu_zero = 1'b0; alu_carry = 1'b0;
    dest = 3'd2; start = 1'b1; rf_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rstw_wr_en_before", rf_wr_en, 1);
    chk("rstw_carry_before", carry_flag, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_outputs", {rf_wr_en, busy, done, err, carry_flag, zero_flag}, 6'b0);
    chk("rstw_latches", {rf_wr_addr, rf_wr_data}, 19'b0);
    @(negedge clk);
    rst_n = 1'b1; rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstw_no_done%0d", i), {done, rf_wr_en, busy}, 3'b0);
    end
    chk("rstw_flags_cleared", {carry_flag, zero_flag}, 2'b00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
